// File: rtl/event_encoder.sv
// event_encoder: collects per-line event strobes into pending bits and
// serialises them as binary indices over a valid/ready stream, one index
// per transfer. Selection is either rotating (round robin) or fixed
// lowest-index-first. Lost events are flagged by a one-cycle overflow pulse.
module event_encoder #(
  parameter int N_IN        = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_IN-1:0]         i_val_in,
  input  logic                    i_out_ready,
  output logic                    o_out_valid,
  output logic [$clog2(N_IN)-1:0] o_out_idx,
  output logic                    o_overflow,
  output logic                    o_busy
);

  localparam int IDX_W = $clog2(N_IN);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [N_IN-1:0]    r_pending;
  logic [IDX_W-1:0]   r_outIdx;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_overflow;

  logic               w_anyPending;
  logic               w_load;
  logic               w_found;
  logic [IDX_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_selIdx;
  logic [N_IN-1:0]    w_loadMask;

  assign w_anyPending = |r_pending;

  // Pick the next pending line, scanning upward from the base and wrapping
  // through IDX_W-bit truncation; the base is the rotating pointer in round
  // robin mode and zero in fixed-priority mode.
  always_comb begin
    w_base   = ROUND_ROBIN ? r_ptr : '0;
    w_found  = 1'b0;
    w_cand   = '0;
    w_selIdx = '0;
    for (int off = 0; off < N_IN; off++) begin
      w_cand = w_base + IDX_W'(off);
      if (!w_found && r_pending[w_cand]) begin
        w_found  = 1'b1;
        w_selIdx = w_cand;
      end
    end
  end

  // One-hot mask of the line being moved into the output register this edge.
  always_comb begin
    w_loadMask = w_load ? (N_IN'(1) << w_selIdx) : '0;
  end

  // Output-register state: a load happens whenever the register is empty or
  // being drained this edge and something is pending, so there is no bubble.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_anyPending) begin
          w_load      = 1'b1;
          w_nextState = FULL;
        end
      end
      FULL: begin
        if (i_out_ready) begin
          if (w_anyPending) begin
            w_load = 1'b1;
          end else begin
            w_nextState = EMPTY;
          end
        end
      end
      default: w_nextState = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pending bits, output index, rotating pointer and the overflow pulse. A new
  // event on a line being loaded this edge re-arms it (set wins); an event on
  // an already pending line that is not loaded is dropped and flagged.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending  <= '0;
      r_outIdx   <= '0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= (r_pending & ~w_loadMask) | i_val_in;
      r_overflow <= |(i_val_in & r_pending & ~w_loadMask);
      if (w_load) begin
        r_outIdx <= w_selIdx;
        r_ptr    <= w_selIdx + IDX_W'(1);
      end
    end
  end

  // Stream outputs decoded straight from the registers.
  always_comb begin
    o_out_valid = (r_state == FULL);
    o_out_idx   = r_outIdx;
    o_overflow  = r_overflow;
    o_busy      = w_anyPending | (r_state == FULL);
  end

endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: scenario tasks for the event encoder. Expected indices
// are queued when events are driven and compared as transfers complete.
// A second instance with fixed priority shares all stimulus.
module tb_event_encoder;

  logic       clk;
  logic       rstN;
  logic [3:0] valIn;
  logic       outReady;
  logic       outValid;
  logic [1:0] outIdx;
  logic       overflow;
  logic       busy;
  logic       fxValid;
  logic [1:0] fxIdx;
  logic       fxOverflow;
  logic       fxBusy;

  int checks   = 0;
  int failures = 0;

  logic [1:0] expQ[$];
  logic [1:0] expFxQ[$];
  logic [1:0] expIdx;

  event_encoder #(.N_IN(4), .ROUND_ROBIN(1'b1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_val_in    (valIn),
    .i_out_ready (outReady),
    .o_out_valid (outValid),
    .o_out_idx   (outIdx),
    .o_overflow  (overflow),
    .o_busy      (busy)
  );

  event_encoder #(.N_IN(4), .ROUND_ROBIN(1'b0)) dutFixed (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_val_in    (valIn),
    .i_out_ready (outReady),
    .o_out_valid (fxValid),
    .o_out_idx   (fxIdx),
    .o_overflow  (fxOverflow),
    .o_busy      (fxBusy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN     = 1'b0;
    valIn    = '0;
    outReady = 1'b0;
    nextCycle();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN     = 1'b0;
    valIn    = 4'b1111;
    outReady = 1'b1;
    nextCycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({outValid, outIdx, overflow, busy} !== 5'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: cycle %0d valid=%b idx=%0d ovf=%b busy=%b, required all 0",
                 c, outValid, outIdx, overflow, busy);
      end
      checks++;
      if ({fxValid, fxIdx, fxOverflow, fxBusy} !== 5'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs_fixed: cycle %0d valid=%b idx=%0d ovf=%b busy=%b, required all 0",
                 c, fxValid, fxIdx, fxOverflow, fxBusy);
      end
      if (c < 2) nextCycle();
    end
    nextCycle();
    rstN  = 1'b1;
    valIn = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_release: cycle %0d valid=%b busy=%b, required 0 0", c, outValid, busy);
      end
      nextCycle();
    end
  endtask

  task automatic test_single();
    expQ.push_back(2'd2);
    valIn    = 4'b0100;
    outReady = 1'b1;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_t0_valid: got %b, required 0", outValid);
    end
    nextCycle();
    valIn = '0;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_t1: valid=%b busy=%b, required 0 1", outValid, busy);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_t2_valid: got %b, required 1", outValid);
    end
    if (outValid === 1'b1 && outReady === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL single_sb: idx %0d emitted, required no transfer", outIdx);
      end else begin
        expIdx = expQ.pop_front();
        if (outIdx !== expIdx) begin
          failures++;
          $display("[TB] FAIL single_idx: got %0d, required %0d", outIdx, expIdx);
        end
      end
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_t3: valid=%b busy=%b, required 0 0", outValid, busy);
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL single_drain: %0d entries left, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_burst();
    doReset();
    expQ.push_back(2'd0);
    expQ.push_back(2'd1);
    expQ.push_back(2'd3);
    valIn    = 4'b1011;
    outReady = 1'b1;
    nextCycle();
    valIn = '0;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL burst_t1_valid: got %b, required 0", outValid);
    end
    for (int c = 2; c <= 4; c++) begin
      nextCycle();
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || fxValid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL burst_gap: cycle t+%0d valid=%b fixed_valid=%b, required 1 1", c, outValid, fxValid);
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL burst_sb: idx %0d emitted, required no transfer", outIdx);
        end else begin
          expIdx = expQ.pop_front();
          if (outIdx !== expIdx || fxIdx !== expIdx) begin
            failures++;
            $display("[TB] FAIL burst_idx: cycle t+%0d got %0d fixed %0d, required %0d", c, outIdx, fxIdx, expIdx);
          end
        end
      end
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL burst_end: valid=%b left=%0d, required 0 0", outValid, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_backpressure();
    expQ.push_back(2'd1);
    expQ.push_back(2'd1);
    valIn    = 4'b0010;
    outReady = 1'b0;
    nextCycle();
    valIn = '0;
    for (int c = 2; c <= 6; c++) begin
      nextCycle();
      valIn = (c == 3 || c == 5) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || outIdx !== 2'd1) begin
        failures++;
        $display("[TB] FAIL bp_hold: cycle t+%0d valid=%b idx=%0d, required 1 1", c, outValid, outIdx);
      end
      checks++;
      if (overflow !== (c == 6)) begin
        failures++;
        $display("[TB] FAIL bp_overflow: cycle t+%0d got %b, required %b", c, overflow, (c == 6));
      end
    end
    for (int c = 7; c <= 8; c++) begin
      nextCycle();
      valIn    = '0;
      outReady = 1'b1;
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || overflow !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_release: cycle t+%0d valid=%b ovf=%b, required 1 0", c, outValid, overflow);
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL bp_sb: idx %0d emitted, required no transfer", outIdx);
        end else begin
          expIdx = expQ.pop_front();
          if (outIdx !== expIdx) begin
            failures++;
            $display("[TB] FAIL bp_idx: cycle t+%0d got %0d, required %0d", c, outIdx, expIdx);
          end
        end
      end
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL bp_end: valid=%b busy=%b left=%0d, required 0 0 0", outValid, busy, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_fairness();
    doReset();
    for (int k = 0; k < 8; k++) begin
      expQ.push_back((k % 2 == 0) ? 2'd0 : 2'd1);
      expFxQ.push_back(2'd0);
    end
    valIn    = 4'b0011;
    outReady = 1'b1;
    nextCycle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fair_t1: valid=%b ovf=%b, required 0 0", outValid, overflow);
    end
    for (int c = 2; c <= 9; c++) begin
      nextCycle();
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (overflow !== 1'b1) begin
          failures++;
          $display("[TB] FAIL fair_overflow: got %b, required 1", overflow);
        end
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL fair_sb: idx %0d emitted, required no transfer", outIdx);
        end else begin
          expIdx = expQ.pop_front();
          if (outIdx !== expIdx) begin
            failures++;
            $display("[TB] FAIL fair_rr_idx: cycle t+%0d got %0d, required %0d", c, outIdx, expIdx);
          end
        end
      end
      if (fxValid === 1'b1 && outReady === 1'b1) begin
        checks++;
        if (expFxQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL fair_fixed_sb: idx %0d emitted, required no transfer", fxIdx);
        end else begin
          expIdx = expFxQ.pop_front();
          if (fxIdx !== expIdx) begin
            failures++;
            $display("[TB] FAIL fair_fixed_idx: cycle t+%0d got %0d, required %0d", c, fxIdx, expIdx);
          end
        end
      end
    end
    checks++;
    if (expQ.size() != 0 || expFxQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL fair_count: left rr=%0d fixed=%0d, required 0 0", expQ.size(), expFxQ.size());
      expQ.delete();
      expFxQ.delete();
    end
    valIn = '0;
  endtask

  task automatic test_mid_reset();
    doReset();
    valIn    = 4'b1111;
    outReady = 1'b0;
    nextCycle();
    valIn = '0;
    nextCycle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1 || outIdx !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_pre: valid=%b idx=%0d busy=%b, required 1 0 1", outValid, outIdx, busy);
    end
    nextCycle();
    rstN = 1'b0;
    nextCycle();
    rstN     = 1'b1;
    outReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({outValid, outIdx, overflow, busy} !== 5'b0 || fxValid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrst_post: cycle %0d valid=%b idx=%0d ovf=%b busy=%b fixed_valid=%b, required all 0",
                 c, outValid, outIdx, overflow, busy, fxValid);
      end
      nextCycle();
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    rstN     = 1'b0;
    valIn    = '0;
    outReady = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_fairness();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
